// File: rtl/shared_debounce_ctrl_if.sv
// Bundle of noisy inputs and debounced outputs for shared_debounce_ctrl.
// The controller side is the slave modport, the stimulus side is master.
interface shared_debounce_ctrl_if #(
    parameter int N = 4
);
    logic [N-1:0] noisy;
    logic [N-1:0] debounced;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic         busy;
    logic [3:0]   owner;

    modport master (
        output noisy,
        input  debounced,
        input  rise,
        input  fall,
        input  busy,
        input  owner
    );

    modport slave (
        input  noisy,
        output debounced,
        output rise,
        output fall,
        output busy,
        output owner
    );
endinterface

// File: rtl/shared_debounce_ctrl.sv
// N-channel debouncer sharing one stability timer, round-robin granted.
// Define DEBOUNCE_EDGE_PULSE_EN to build the rise/fall pulse outputs.
module shared_debounce_ctrl #(
    parameter int N           = 4,
    parameter int FINAL_VALUE = 1_999_999,
    parameter int CW          = 21
) (
    input  logic                  clk,
    input  logic                  reset,
    shared_debounce_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        COMMIT
    } state_t;

    state_t        state;
    logic [N-1:0]  meta;
    logic [N-1:0]  sync;
    logic [N-1:0]  debounced;
    logic [CW-1:0] count;
    logic [3:0]    rr_ptr;
    logic [3:0]    owner;
    logic          busy;

    logic [N-1:0]  pending;
    logic [15:0]   sync16;
    logic [15:0]   deb16;
    logic [N-1:0]  own_hot;
    logic [3:0]    next_ptr;
    logic          grant_ok;
    logic [3:0]    grant_idx;

    function automatic logic [3:0] wrap_add(
        input logic [3:0]  base,
        input int unsigned k
    );
        logic [4:0] s;
        s = {1'b0, base} + 5'(k);
        if (s >= 5'(N)) begin
            s = s - 5'(N);
        end
        return s[3:0];
    endfunction

    assign pending  = sync ^ debounced;
    assign sync16   = 16'(sync);
    assign deb16    = 16'(debounced);
    assign own_hot  = N'(1) << owner;
    assign next_ptr = wrap_add(owner, 1);

    // Scan downward so the nearest pending channel from rr_ptr wins.
    always_comb begin
        grant_ok  = 1'b0;
        grant_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (pending[wrap_add(rr_ptr, k)]) begin
                grant_ok  = 1'b1;
                grant_idx = wrap_add(rr_ptr, k);
            end
        end
    end

`ifdef DEBOUNCE_EDGE_PULSE_EN
    logic [N-1:0] rise;
    logic [N-1:0] fall;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            meta      <= '0;
            sync      <= '0;
            debounced <= '0;
            count     <= '0;
            rr_ptr    <= '0;
            owner     <= '0;
            busy      <= 1'b0;
`ifdef DEBOUNCE_EDGE_PULSE_EN
            rise      <= '0;
            fall      <= '0;
`endif
        end else begin
            meta <= bus.noisy;
            sync <= meta;
`ifdef DEBOUNCE_EDGE_PULSE_EN
            rise <= '0;
            fall <= '0;
`endif
            unique case (state)
                IDLE: begin
                    if (grant_ok) begin
                        owner <= grant_idx;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    // A bounce back outranks reaching terminal count.
                    if (sync16[owner] == deb16[owner]) begin
                        rr_ptr <= next_ptr;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else if (count == CW'(FINAL_VALUE)) begin
                        state <= COMMIT;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                COMMIT: begin
                    debounced <= debounced ^ own_hot;
                    rr_ptr    <= next_ptr;
                    busy      <= 1'b0;
                    state     <= IDLE;
`ifdef DEBOUNCE_EDGE_PULSE_EN
                    if (deb16[owner]) begin
                        fall <= own_hot;
                    end else begin
                        rise <= own_hot;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.debounced = debounced;
    assign bus.busy      = busy;
    assign bus.owner     = owner;

`ifdef DEBOUNCE_EDGE_PULSE_EN
    assign bus.rise = rise;
    assign bus.fall = fall;
`else
    assign bus.rise = '0;
    assign bus.fall = '0;
`endif
endmodule

// File: tb/tb_shared_debounce_ctrl.sv
// Directed bench for shared_debounce_ctrl with N=4, FINAL_VALUE=9.
// Covers step latency, bounce abort, contention order, fairness, reset.
module tb_shared_debounce_ctrl;
    localparam int N  = 4;
    localparam int FV = 9;
    localparam int CW = 4;
`ifdef DEBOUNCE_EDGE_PULSE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   pulse_cnt = 0;
    int   grant_cnt = 0;
    int   onehot_err = 0;
    logic busy_prev = 1'b0;

    shared_debounce_ctrl_if #(.N(N)) bus ();

    shared_debounce_ctrl #(
        .N(N),
        .FINAL_VALUE(FV),
        .CW(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset) begin
            pulse_cnt = pulse_cnt + $countones(bus.rise | bus.fall);
            if ($countones(bus.rise | bus.fall) > 1) onehot_err++;
            if (bus.busy && !busy_prev) grant_cnt++;
        end
        busy_prev = bus.busy;
    end

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Counts edges from the first one sampling the new level; bounded.
    task automatic wait_deb(
        input  int   ch,
        input  logic val,
        input  int   start,
        output int   edges
    );
        edges = start;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end while (bus.debounced[ch] !== val && edges < 200);
    endtask

    int e, p0, g0, lows;
    int t[N];
    logic bad;

    initial begin
        reset = 1'b0;
        bus.noisy = '0;
        repeat (2) @(negedge clk);
        check("rst_deb", 32'(bus.debounced), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_owner", 32'(bus.owner), 0);
        check("rst_pulse", 32'(bus.rise | bus.fall), 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // single step on channel 0
        bus.noisy[0] = 1'b1;
        repeat (5) @(negedge clk);
        check("step_busy", 32'(bus.busy), 1);
        check("step_owner", 32'(bus.owner), 0);
        wait_deb(0, 1'b1, 5, e);
        check("step_lat", e, FV + 5);
        check("step_rise", 32'(bus.rise), EDGE ? 1 : 0);
        check("step_busy_gap", 32'(bus.busy), 0);
        @(negedge clk);
        check("step_rise_1cyc", 32'(bus.rise), 0);
        check("step_deb", 32'(bus.debounced), 4'b0001);

        repeat (3) @(negedge clk);
        bus.noisy[0] = 1'b0;
        wait_deb(0, 1'b0, 0, e);
        check("fall_lat", e, FV + 5);
        check("fall_pulse", 32'(bus.fall), EDGE ? 1 : 0);
        check("fall_norise", 32'(bus.rise), 0);

        // bounce on channel 1
        repeat (3) @(negedge clk);
        p0 = pulse_cnt;
        g0 = grant_cnt;
        bad = 1'b0;
        bus.noisy[1] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus.debounced[1]) bad = 1'b1;
        end
        bus.noisy[1] = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.debounced[1]) bad = 1'b1;
        end
        check("bnc_pulse_early", pulse_cnt - p0, 0);
        bus.noisy[1] = 1'b1;
        wait_deb(1, 1'b1, 0, e);
        check("bnc_early_deb", 32'(bad), 0);
        check("bnc_lat", e, FV + 5);
        check("bnc_grants", grant_cnt - g0, 2);
        check("bnc_pulses", pulse_cnt - p0, EDGE ? 1 : 0);

        // contention from rr_ptr = 0
        @(negedge clk);
        reset = 1'b0;
        bus.noisy = '0;
        @(negedge clk);
        reset = 1'b1;
        bus.noisy = 4'hF;
        foreach (t[i]) t[i] = 0;
        lows = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            @(negedge clk);
            for (int ch = 0; ch < N; ch++) begin
                if (t[ch] == 0 && bus.debounced[ch]) t[ch] = c;
            end
            if (t[0] != 0 && t[3] == 0 && !bus.busy) lows++;
            if (bus.debounced == 4'hF) break;
        end
        check("cont_t0", t[0], FV + 5);
        check("cont_t1", t[1] - t[0], 12);
        check("cont_t2", t[2] - t[1], 12);
        check("cont_t3", t[3] - t[2], 12);
        check("cont_gaps", lows, 3);

        // fairness: channel 0 keeps bouncing, channel 3 steady
        p0 = pulse_cnt;
        g0 = grant_cnt;
        bus.noisy[3] = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (c % 3 == 0) bus.noisy[0] = ~bus.noisy[0];
            @(negedge clk);
            if (!bus.debounced[3]) break;
        end
        check("fair_deb3", 32'(bus.debounced[3]), 0);
        check("fair_within_n", 32'(grant_cnt - g0 <= N), 1);
        bus.noisy[0] = 1'b1;
        repeat (30) @(negedge clk);
        check("fair_deb", 32'(bus.debounced), 4'b0111);
        check("fair_pulses", pulse_cnt - p0, EDGE ? 1 : 0);

        // reset while channel 3 counts (counter = 5)
        p0 = pulse_cnt;
        bus.noisy[3] = 1'b1;
        repeat (8) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("arst_deb", 32'(bus.debounced), 0);
        check("arst_busy", 32'(bus.busy), 0);
        check("arst_owner", 32'(bus.owner), 0);
        check("arst_pulse", 32'(bus.rise | bus.fall), 0);
        repeat (2) @(negedge clk);
        check("arst_nopulse", pulse_cnt - p0, 0);
        reset = 1'b1;
        wait_deb(0, 1'b1, 0, e);
        check("post_rst_lat", e, FV + 5);
        for (int c = 0; c < 100; c++) begin
            if (bus.debounced == 4'hF) break;
            @(negedge clk);
        end
        check("post_rst_all", 32'(bus.debounced), 4'hF);

        repeat (3) @(negedge clk);
        check("onehot", onehot_err, 0);
        check("pulse_total", pulse_cnt, EDGE ? 12 : 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
